// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational 16-bit adder/flag ALU among NREQ requesters.
// One request at a time: IDLE accepts, EXEC drives the ALU, RESP holds the result until it is taken.
module alu_share_ctrl #(
   parameter  int NREQ = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [16*NREQ-1:0]   i_req_x,
   input  logic [16*NREQ-1:0]   i_req_y,
   output logic [15:0]          o_alu_x,
   output logic [15:0]          o_alu_y,
   input  logic [15:0]          i_alu_z,
   input  logic [4:0]           i_alu_flags,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [IDW-1:0]       o_rsp_id,
   output logic [15:0]          o_rsp_z,
   output logic [4:0]           o_rsp_flags,
   output logic                 o_busy,
   output logic [15:0]          o_op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [15:0]      r_alu_x;
   logic [15:0]      r_alu_y;
   logic             r_rsp_valid;
   logic [IDW-1:0]   r_rsp_id;
   logic [15:0]      r_rsp_z;
   logic [4:0]       r_rsp_flags;
   logic [15:0]      r_op_count;

   logic [15:0]      w_x [NREQ];
   logic [15:0]      w_y [NREQ];
   logic [IDW-1:0]   w_idx;
   logic [IDW-1:0]   w_winner;
   logic [IDW-1:0]   w_next_ptr;
   logic             w_found;
   logic             w_grant;

   // Round-robin search starting at r_ptr; first valid requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = {IDW{1'b0}};
      w_idx    = {IDW{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         w_x[k]   = i_req_x[16*k +: 16];
         w_y[k]   = i_req_y[16*k +: 16];
         w_idx    = IDW'((int'(r_ptr) + k) % NREQ);
         w_winner = (i_req_valid[w_idx] && !w_found) ? w_idx : w_winner;
         w_found  = w_found | i_req_valid[w_idx];
      end
      w_next_ptr = (w_winner == IDW'(NREQ - 1)) ? {IDW{1'b0}} : w_winner + IDW'(1);
      w_grant    = (r_state == S_IDLE) && !i_rst && w_found;
   end

   // Grant is combinational so a requester sees ready in the same cycle it raises valid.
   always_comb begin
      if (w_grant) begin
         o_req_ready = NREQ'(1) << w_winner;
      end else begin
         o_req_ready = {NREQ{1'b0}};
      end
   end

   // Controller FSM with all datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= {IDW{1'b0}};
         r_id        <= {IDW{1'b0}};
         r_alu_x     <= 16'h0000;
         r_alu_y     <= 16'h0000;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= {IDW{1'b0}};
         r_rsp_z     <= 16'h0000;
         r_rsp_flags <= 5'b00000;
         r_op_count  <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_alu_x <= w_x[w_winner];
                  r_alu_y <= w_y[w_winner];
                  r_id    <= w_winner;
                  r_ptr   <= w_next_ptr;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_z     <= i_alu_z;
               r_rsp_flags <= i_alu_flags;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_op_count  <= r_op_count + 16'd1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_alu_x     = r_alu_x;
   assign o_alu_y     = r_alu_y;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_z     = r_rsp_z;
   assign o_rsp_flags = r_rsp_flags;
   assign o_busy      = (r_state != S_IDLE);
   assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_share_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_x;
   logic [63:0] req_y;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [15:0] alu_z;
   logic [4:0]  alu_flags;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_z;
   logic [4:0]  rsp_flags;
   logic        busy;
   logic [15:0] op_count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] z;
      logic [4:0]  f;
   } exp_t;
   exp_t sb[$];

   alu_share_ctrl #(.NREQ(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_x(req_x), .i_req_y(req_y),
      .o_alu_x(alu_x), .o_alu_y(alu_y),
      .i_alu_z(alu_z), .i_alu_flags(alu_flags),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_z(rsp_z), .o_rsp_flags(rsp_flags),
      .o_busy(busy), .o_op_count(op_count)
   );

   // Shared ALU: flags {Overflow, even Parity, Carry, Zero, Sign}
   logic [16:0] alu_sum;
   assign alu_sum   = {1'b0, alu_x} + {1'b0, alu_y};
   assign alu_z     = alu_sum[15:0];
   assign alu_flags = {(alu_x[15] == alu_y[15]) && (alu_z[15] != alu_x[15]),
                       ~^alu_z, alu_sum[16], alu_z == 16'h0000, alu_z[15]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input int id, input logic [15:0] x, input logic [15:0] y);
      exp_t e;
      logic [16:0] s;
      s    = {1'b0, x} + {1'b0, y};
      e.id = 2'(id);
      e.z  = s[15:0];
      e.f[4] = (x[15] & y[15] & ~s[15]) | (~x[15] & ~y[15] & s[15]);
      e.f[3] = ~^s[15:0];
      e.f[2] = s[16];
      e.f[1] = (s[15:0] == 16'h0000);
      e.f[0] = s[15];
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tmo(input string tag);
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tmo({tag, "_sb_empty"});
      end else begin
         e = sb.pop_front();
         check({tag, "_id"},    32'(rsp_id),    32'(e.id));
         check({tag, "_z"},     32'(rsp_z),     32'(e.z));
         check({tag, "_flags"}, 32'(rsp_flags), 32'(e.f));
      end
   endtask

   // Returns at 1 time unit after the handshake edge.
   task automatic do_req(input int id, input logic [15:0] x, input logic [15:0] y,
                         input bit push, input string tag);
      bit got;
      got = 1'b0;
      req_x[16*id +: 16] = x;
      req_y[16*id +: 16] = y;
      req_valid = 4'b0001 << id;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         if (req_ready != 4'b0000) begin
            got = 1'b1;
            check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
            if (push) sb.push_back(model(id, x, y));
         end
         @(posedge clk); #1;
      end
      req_valid = 4'b0000;
      if (!got) tmo({tag, "_grant"});
   endtask

   task automatic wait_rsp(input string tag);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      if (!got) tmo({tag, "_rsp"});
   endtask

   task automatic take_rsp(input string tag);
      pop_check(tag);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n_acc;
      int n_rsp;
      int last_acc;
      logic [15:0] tx [4];
      logic [15:0] ty [4];
      logic [15:0] hz;

      rst = 1'b1; req_valid = 4'b1111; req_x = 64'h0; req_y = 64'h0; rsp_ready = 1'b0;

      // Reset: no grant while rst is high, registers cleared.
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_ready2", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0000;
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_z",     32'(rsp_z),     32'h0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
      check("rst_rsp_id",    32'(rsp_id),    32'h0);
      check("rst_op_count",  32'(op_count),  32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_alu_x",     32'(alu_x),     32'h0);
      @(posedge clk); #1;

      // 1) Signed overflow into the sign bit, with latency check.
      do_req(1, 16'h7FFF, 16'h0001, 1'b1, "t1");
      @(negedge clk);
      check("t1_exec_busy",  32'(busy),      32'h1);
      check("t1_exec_valid", 32'(rsp_valid), 32'h0);
      check("t1_alu_x",      32'(alu_x),     32'h7FFF);
      check("t1_alu_y",      32'(alu_y),     32'h0001);
      @(negedge clk);
      check("t1_latency",    32'(rsp_valid), 32'h1);
      check("t1_lit_id",     32'(rsp_id),    32'h1);
      check("t1_lit_z",      32'(rsp_z),     32'h8000);
      check("t1_lit_flags",  32'(rsp_flags), 32'(5'b10001));
      take_rsp("t1");
      check("t1_done_valid", 32'(rsp_valid), 32'h0);
      check("t1_op_count",   32'(op_count),  32'h1);

      // 2) Carry out to zero.
      do_req(2, 16'hFFFF, 16'h0001, 1'b1, "t2");
      wait_rsp("t2");
      check("t2_lit_id",    32'(rsp_id),    32'h2);
      check("t2_lit_z",     32'(rsp_z),     32'h0000);
      check("t2_lit_flags", 32'(rsp_flags), 32'(5'b01110));
      take_rsp("t2");
      check("t2_op_count",  32'(op_count),  32'h2);

      // 4) Consumer stalls for 5 cycles with all requesters pending.
      do_req(3, 16'h1234, 16'h4321, 1'b1, "t4");
      rsp_ready = 1'b0;
      wait_rsp("t4");
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         check("t4_hold_z",     32'(rsp_z),     32'h5555);
         check("t4_hold_id",    32'(rsp_id),    32'h3);
         check("t4_hold_flags", 32'(rsp_flags), 32'(model(3, 16'h1234, 16'h4321).f));
         check("t4_hold_valid", 32'(rsp_valid), 32'h1);
         check("t4_hold_ready", 32'(req_ready), 32'h0);
         check("t4_hold_busy",  32'(busy),      32'h1);
         @(negedge clk);
      end
      pop_check("t4");
      @(posedge clk); #1;
      rsp_ready = 1'b1; req_valid = 4'b0000;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("t4_idle_busy",  32'(busy),      32'h0);
      check("t4_idle_valid", 32'(rsp_valid), 32'h0);
      check("t4_op_count",   32'(op_count),  32'h3);

      // 5) Reset in EXEC drops the operation; ptr returns to 0.
      do_req(2, 16'h00AA, 16'h0055, 1'b0, "t5");
      check("t5_exec_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_busy",      32'(busy),      32'h0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
      check("t5_op_count",  32'(op_count),  32'h0);
      check("t5_rsp_z",     32'(rsp_z),     32'h0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(rsp_valid), 32'h0);
      end
      @(posedge clk); #1;

      // 3) All requesters valid: rotation 0,1,2,3,0,1 at one accept per 3 cycles.
      for (int i = 0; i < 4; i++) begin
         tx[i] = 16'($urandom);
         ty[i] = 16'($urandom);
         req_x[16*i +: 16] = tx[i];
         req_y[16*i +: 16] = ty[i];
      end
      req_valid = 4'b1111;
      n_acc = 0; n_rsp = 0; last_acc = 0;
      for (int c = 0; c < 60 && n_rsp < 6; c++) begin
         @(negedge clk);
         if (req_ready != 4'b0000 && n_acc < 6) begin
            check("t3_grant", 32'(req_ready), 32'(4'b0001 << (n_acc % 4)));
            if (n_acc > 0) check("t3_spacing", 32'(c - last_acc), 32'd3);
            sb.push_back(model(n_acc % 4, tx[n_acc % 4], ty[n_acc % 4]));
            last_acc = c;
            n_acc++;
         end
         if (rsp_valid) begin
            check("t3_op_count_run", 32'(op_count), 32'(n_rsp));
            pop_check("t3");
            n_rsp++;
         end
         @(posedge clk); #1;
         if (n_acc == 6) req_valid = 4'b0000;
      end
      check("t3_rsp_total", 32'(n_rsp), 32'd6);
      check("t3_op_count",  32'(op_count), 32'h6);

      // 6) op_count wrap from 0xFFFF.
      force dut.r_op_count = 16'hFFFF;
      #1;
      release dut.r_op_count;
      @(negedge clk);
      check("t6_preload", 32'(op_count), 32'hFFFF);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      do_req(0, 16'h8000, 16'h8000, 1'b1, "t6");
      wait_rsp("t6");
      hz = rsp_z;
      check("t6_z", 32'(hz), 32'h0000);
      take_rsp("t6");
      check("t6_wrap", 32'(op_count), 32'h0000);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
